// File: rtl/compare_debounce.sv
// Registered WIDTH-bit A-versus-B comparator with unsigned/two's-complement mode per sample,
// followed by a debouncer that moves AGEB only after DEBOUNCE consecutive disagreeing samples.
module compare_debounce #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic             Valid,
    input  logic             Signed,
    output logic             AGTB,
    output logic             AEQB,
    output logic             RawGE,
    output logic             OutValid,
    output logic             AGEB,
    output logic             Changed
);

    localparam int                CNT_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             signed_q, signed_d;
    logic             valid_q, valid_d;
    logic             agtb_q, agtb_d, aeqb_q, aeqb_d, rawge_q, rawge_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ageb_q, ageb_d;
    logic             changed_q, changed_d;

    // Inverting the sign bit maps two's-complement order onto unsigned order.
    logic [WIDTH-1:0] a_key, b_key;
    logic             a_gt_b, a_eq_b;

    assign a_key  = {a_q[WIDTH-1] ^ signed_q, a_q[WIDTH-2:0]};
    assign b_key  = {b_q[WIDTH-1] ^ signed_q, b_q[WIDTH-2:0]};
    assign a_gt_b = a_key > b_key;
    assign a_eq_b = a_q == b_q;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        a_d         = a_q;
        b_d         = b_q;
        signed_d    = signed_q;
        valid_d     = Valid;
        agtb_d      = agtb_q;
        aeqb_d      = aeqb_q;
        rawge_d     = rawge_q;
        out_valid_d = valid_q;
        cnt_d       = cnt_q;
        ageb_d      = ageb_q;
        changed_d   = 1'b0;

        if (Valid) begin
            a_d      = DataA;
            b_d      = DataB;
            signed_d = Signed;
        end

        if (valid_q) begin
            agtb_d  = a_gt_b;
            aeqb_d  = a_eq_b;
            rawge_d = a_gt_b | a_eq_b;
        end

        if (out_valid_q) begin
            if (rawge_q == ageb_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                ageb_d    = rawge_q;
                cnt_d     = '0;
                changed_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
        if (RESET) begin
            a_q         <= '0;
            b_q         <= '0;
            signed_q    <= 1'b0;
            valid_q     <= 1'b0;
            agtb_q      <= 1'b0;
            aeqb_q      <= 1'b0;
            rawge_q     <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            ageb_q      <= 1'b0;
            changed_q   <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            signed_q    <= signed_d;
            valid_q     <= valid_d;
            agtb_q      <= agtb_d;
            aeqb_q      <= aeqb_d;
            rawge_q     <= rawge_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            ageb_q      <= ageb_d;
            changed_q   <= changed_d;
        end
    end

    assign AGTB     = agtb_q;
    assign AEQB     = aeqb_q;
    assign RawGE    = rawge_q;
    assign OutValid = out_valid_q;
    assign AGEB     = ageb_q;
    assign Changed  = changed_q;

endmodule

// File: tb/tb_compare_debounce.sv
// Scoreboard bench for compare_debounce: an 8-bit/DEBOUNCE=4 instance and a 16-bit/DEBOUNCE=1
// instance, driven with directed samples whose expected flags and AGEB/Changed are hand-computed.
module tb_compare_debounce;

    typedef struct {
        logic agtb;
        logic aeqb;
        logic ge;
        logic ageb;
        logic chg;
        int   cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        v8, s8, v16, s16;
    logic        gt8, eq8, ge8, ov8, ageb8, chg8;
    logic        gt16, eq16, ge16, ov16, ageb16, chg16;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   armed = 1'b0;
    exp_t q8[$], q16[$];
    exp_t pe8, pe16;
    bit   pend8 = 1'b0, pend16 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    compare_debounce #(.WIDTH(8), .DEBOUNCE(4)) dut8 (
        .CLK(clk), .RESET(reset), .DataA(a8), .DataB(b8), .Valid(v8), .Signed(s8),
        .AGTB(gt8), .AEQB(eq8), .RawGE(ge8), .OutValid(ov8), .AGEB(ageb8), .Changed(chg8)
    );

    compare_debounce #(.WIDTH(16), .DEBOUNCE(1)) dut16 (
        .CLK(clk), .RESET(reset), .DataA(a16), .DataB(b16), .Valid(v16), .Signed(s16),
        .AGTB(gt16), .AEQB(eq16), .RawGE(ge16), .OutValid(ov16), .AGEB(ageb16), .Changed(chg16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: raw flags and arrival cycle when OutValid shows, AGEB/Changed one cycle later.
    always @(negedge clk) begin
        if (armed) begin
            if (pend8) begin
                check("ageb8", ageb8, pe8.ageb);
                check("changed8", chg8, pe8.chg);
                pend8 = 1'b0;
            end else begin
                check("changed8_idle", chg8, 1'b0);
            end
            if (q8.size() == 0) begin
                check("outvalid8_unexpected", ov8, 1'b0);
            end else if (ov8) begin
                pe8 = q8.pop_front();
                check("latency8", cyc, pe8.cyc);
                check("agtb8", gt8, pe8.agtb);
                check("aeqb8", eq8, pe8.aeqb);
                check("rawge8", ge8, pe8.ge);
                pend8 = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (pend16) begin
                check("ageb16", ageb16, pe16.ageb);
                check("changed16", chg16, pe16.chg);
                pend16 = 1'b0;
            end else begin
                check("changed16_idle", chg16, 1'b0);
            end
            if (q16.size() == 0) begin
                check("outvalid16_unexpected", ov16, 1'b0);
            end else if (ov16) begin
                pe16 = q16.pop_front();
                check("latency16", cyc, pe16.cyc);
                check("agtb16", gt16, pe16.agtb);
                check("aeqb16", eq16, pe16.aeqb);
                check("rawge16", ge16, pe16.ge);
                pend16 = 1'b1;
            end
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic gt, input logic eq, input logic ge,
                         input logic ageb, input logic chg);
        exp_t e;
        @(posedge clk); #1;
        a8 = a; b8 = b; s8 = s; v8 = 1'b1;
        e.agtb = gt; e.aeqb = eq; e.ge = ge; e.ageb = ageb; e.chg = chg; e.cyc = cyc + 2;
        q8.push_back(e);
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic gt, input logic eq, input logic ge,
                          input logic ageb, input logic chg);
        exp_t e;
        @(posedge clk); #1;
        a16 = a; b16 = b; s16 = s; v16 = 1'b1;
        e.agtb = gt; e.aeqb = eq; e.ge = ge; e.ageb = ageb; e.chg = chg; e.cyc = cyc + 2;
        q16.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        v8 = 1'b0; v16 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (q8.size() == 0 && q16.size() == 0 && !pend8 && !pend16) break;
        end
        check("drain8", q8.size() + int'(pend8), 0);
        check("drain16", q16.size() + int'(pend16), 0);
    endtask

    task automatic pulse_reset();
        idle();
        drain();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a live sample presented: everything stays zero and the sample is dropped.
        reset = 1'b1;
        a8 = 8'hFF; b8 = 8'h00; s8 = 1'b0; v8 = 1'b1;
        a16 = '0; b16 = '0; s16 = 1'b0; v16 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_agtb", gt8, 1'b0);
            check("rst_aeqb", eq8, 1'b0);
            check("rst_rawge", ge8, 1'b0);
            check("rst_outvalid", ov8, 1'b0);
            check("rst_ageb", ageb8, 1'b0);
            check("rst_changed", chg8, 1'b0);
        end
        reset = 1'b0;
        v8 = 1'b0;
        armed = 1'b1;
        repeat (3) @(negedge clk);

        // Unsigned vs signed; AGEB stays 0 and the run counter is cleared by the final agreeing sample.
        send8(8'h80, 8'h01, 1'b0, 1, 0, 1, 0, 0);
        send8(8'h80, 8'h01, 1'b1, 0, 0, 0, 0, 0);
        send8(8'h7F, 8'h7F, 1'b0, 0, 1, 1, 0, 0);
        send8(8'h7F, 8'h7F, 1'b1, 0, 1, 1, 0, 0);
        send8(8'hFF, 8'h01, 1'b1, 0, 0, 0, 0, 0);

        // Four back-to-back A>B samples flip AGEB on the fourth.
        send8(8'd10, 8'd5, 1'b0, 1, 0, 1, 0, 0);
        send8(8'd10, 8'd5, 1'b0, 1, 0, 1, 0, 0);
        send8(8'd10, 8'd5, 1'b0, 1, 0, 1, 0, 0);
        send8(8'd10, 8'd5, 1'b0, 1, 0, 1, 1, 1);

        // Run restart: an agreeing A<B sample after three A>=B samples resets the count.
        pulse_reset();
        send8(8'd5, 8'd5, 1'b0, 0, 1, 1, 0, 0);
        send8(8'd5, 8'd5, 1'b0, 0, 1, 1, 0, 0);
        send8(8'd5, 8'd5, 1'b0, 0, 1, 1, 0, 0);
        send8(8'd3, 8'd9, 1'b0, 0, 0, 0, 0, 0);
        send8(8'd5, 8'd5, 1'b0, 0, 1, 1, 0, 0);
        send8(8'd5, 8'd5, 1'b0, 0, 1, 1, 0, 0);
        send8(8'd5, 8'd5, 1'b0, 0, 1, 1, 0, 0);
        send8(8'd5, 8'd5, 1'b0, 0, 1, 1, 1, 1);
        idle();
        drain();

        // Gapped run from AGEB=1: idle cycles between samples do not break the count.
        for (int i = 0; i < 4; i++) begin
            send8(8'd1, 8'd2, 1'b0, 0, 0, 0, (i == 3) ? 1'b0 : 1'b1, (i == 3) ? 1'b1 : 1'b0);
            repeat (3) idle();
        end
        drain();

        // WIDTH=16, DEBOUNCE=1: AGEB follows RawGE on every sample, Changed high throughout.
        pulse_reset();
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) send16(16'h8000, 16'h7FFF, 1'b0, 1, 0, 1, 1, 1);
            else            send16(16'h8000, 16'h7FFF, 1'b1, 0, 0, 0, 0, 1);
        end
        idle();
        drain();
        @(negedge clk);
        check("ageb16_before_reset", ageb16, 1'b1);
        pulse_reset();
        @(negedge clk);
        check("ageb16_after_reset", ageb16, 1'b0);
        check("ageb8_after_reset", ageb8, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
